// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one external ALU between two requesters.
// Arbitration is round-robin. The block drives the shared ALU inputs, captures
// the ALU result and zero flag, and holds each response until its owner takes it.
//
// Optional build macro: ALU_ARB_STATS_EN adds the saturating counters
// grant0_cnt, grant1_cnt and stall_cnt.
//
// Ports:
//   clk, reset                    clock (rising edge), async active-high reset
//   req{0,1}_valid/ready          request handshake (ready is combinational)
//   req{0,1}_srca/srcb/ctrl       request operands and ALU control code
//   rsp{0,1}_valid/ready          response handshake
//   rsp{0,1}_result/zero          captured ALU result and zero flag
//   alu_srca/srcb/ctrl            to the shared ALU (zero when no grant)
//   alu_result/zero               from the shared ALU
//   grant0_cnt/grant1_cnt/stall_cnt  (ALU_ARB_STATS_EN only) statistics
module alu_share_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_srca,
    input  logic [DATA_W-1:0] req0_srcb,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_srca,
    input  logic [DATA_W-1:0] req1_srcb,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
`ifdef ALU_ARB_STATS_EN
    output logic [15:0]       grant0_cnt,
    output logic [15:0]       grant1_cnt,
    output logic [15:0]       stall_cnt,
`endif
    output logic [DATA_W-1:0] alu_srca,
    output logic [DATA_W-1:0] alu_srcb,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner;
    logic              last_grant;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;

    logic              owner_ready;
    logic              slot_free;
    logic              any_valid;
    logic              grant_vld;
    logic              grant_id;

    // Grant decision: the slot frees when idle or when the held response drains.
    always_comb begin
        owner_ready = owner ? rsp1_ready : rsp0_ready;
        slot_free   = (state == IDLE) || owner_ready;
        any_valid   = req0_valid || req1_valid;
        grant_vld   = slot_free && any_valid;
        // On a tie the requester that did not win last time goes next.
        grant_id    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (slot_free) begin
            state_nxt = grant_vld ? HOLD : IDLE;
        end
    end

    // Output logic: request handshakes, ALU operand mux, response qualification.
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        alu_srca    = '0;
        alu_srcb    = '0;
        alu_ctrl    = '0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        rsp0_result = '0;
        rsp1_result = '0;
        rsp0_zero   = 1'b0;
        rsp1_zero   = 1'b0;
        if (grant_vld) begin
            req0_ready = ~grant_id;
            req1_ready = grant_id;
            alu_srca   = grant_id ? req1_srca : req0_srca;
            alu_srcb   = grant_id ? req1_srcb : req0_srcb;
            alu_ctrl   = grant_id ? req1_ctrl : req0_ctrl;
        end
        if (state == HOLD) begin
            rsp0_valid = ~owner;
            rsp1_valid = owner;
        end
        if (rsp0_valid) begin
            rsp0_result = result_q;
            rsp0_zero   = zero_q;
        end
        if (rsp1_valid) begin
            rsp1_result = result_q;
            rsp1_zero   = zero_q;
        end
    end

    // Result capture and ownership tracking; only updated on a grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            result_q   <= '0;
            zero_q     <= 1'b0;
        end else if (grant_vld) begin
            owner      <= grant_id;
            last_grant <= grant_id;
            result_q   <= alu_result;
            zero_q     <= alu_zero;
        end
    end

`ifdef ALU_ARB_STATS_EN
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating grant and stall counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant0_cnt <= '0;
            grant1_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (grant_vld && !grant_id && grant0_cnt != CNT_MAX) begin
                grant0_cnt <= grant0_cnt + CNT_W'(1);
            end
            if (grant_vld && grant_id && grant1_cnt != CNT_MAX) begin
                grant1_cnt <= grant1_cnt + CNT_W'(1);
            end
            if (any_valid && !grant_vld && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
